dclk_timekeeper: RTL



---
 rtl/dclk_pkg.sv | 25 ++
 rtl/bcd2_cnt.sv | 67 ++++++
 rtl/dclk_timekeeper.sv | 118 +++++++++++
 3 files changed

// File: rtl/dclk_pkg.sv
// Shared definitions for the digital clock timekeeper: state encoding,
// display constants and field limits.
package dclk_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_SET_HOUR = 2'd1,
      ST_SET_MIN  = 2'd2,
      ST_SET_SEC  = 2'd3
   } state_t;

   localparam logic [5:0] DP_PATTERN = 6'b010_100;
   localparam logic [5:0] TW_HOUR    = 6'b110_000;
   localparam logic [5:0] TW_MIN     = 6'b001_100;
   localparam logic [5:0] TW_SEC     = 6'b000_011;

   localparam int HOUR_MAX   = 23;
   localparam int MINSEC_MAX = 59;

   // SET_SEC wraps back to RUN through the natural 2-bit overflow.
   function automatic state_t next_mode(input state_t s);
      return state_t'(s + 2'd1);
   endfunction

endpackage

// File: rtl/bcd2_cnt.sv
// Two-digit BCD up/down counter wrapping between 00 and MAX; carry flags
// the MAX->00 step on inc so the caller can chain fields.
module bcd2_cnt #(
   parameter int MAX = 59
) (
   input  logic       clk,
   input  logic       ld_zero,
   input  logic       inc,
   input  logic       dec,
   output logic [3:0] tens,
   output logic [3:0] units,
   output logic       carry
);

   localparam logic [3:0] MAX_T = 4'(MAX / 10);
   localparam logic [3:0] MAX_U = 4'(MAX % 10);

   logic [3:0] tens_q, tens_d, units_q, units_d;
   logic       at_max, at_zero;

   assign at_max  = (tens_q == MAX_T) && (units_q == MAX_U);
   assign at_zero = (tens_q == 4'd0) && (units_q == 4'd0);
   assign carry   = inc && !dec && at_max;

   always_comb begin
      tens_d  = tens_q;
      units_d = units_q;
      if (inc && !dec) begin
         if (at_max) begin
            tens_d  = 4'd0;
            units_d = 4'd0;
         end else if (units_q == 4'd9) begin
            tens_d  = tens_q + 4'd1;
            units_d = 4'd0;
         end else begin
            units_d = units_q + 4'd1;
         end
      end else if (dec && !inc) begin
         if (at_zero) begin
            tens_d  = MAX_T;
            units_d = MAX_U;
         end else if (units_q == 4'd0) begin
            tens_d  = tens_q - 4'd1;
            units_d = 4'd9;
         end else begin
            units_d = units_q - 4'd1;
         end
      end else begin
         tens_d  = tens_q;
         units_d = units_q;
      end
   end

   always_ff @(posedge clk) begin
      if (ld_zero) begin
         tens_q  <= 4'd0;
         units_q <= 4'd0;
      end else begin
         tens_q  <= tens_d;
         units_q <= units_d;
      end
   end

   assign tens  = tens_q;
   assign units = units_q;

endmodule

// File: rtl/dclk_timekeeper.sv
// Digital clock timekeeping core: 1 Hz prescaler, run/set mode FSM and the
// hour/min/sec BCD fields, presented in the form the display shifter expects.
module dclk_timekeeper
   import dclk_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int TICK_CNT = CLK_FREQ
) (
   input  logic       sysclk,
   input  logic       rst,
   input  logic       key_mode,
   input  logic       key_inc,
   input  logic       key_dec,
   output logic       valid_sd,
   output logic [5:0] twinkle,
   output logic [5:0] dp,
   output logic [3:0] num6,
   output logic [3:0] num5,
   output logic [3:0] num4,
   output logic [3:0] num3,
   output logic [3:0] num2,
   output logic [3:0] num1,
   output logic [1:0] mode
);

   localparam int PW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CNT - 1);

   state_t        mode_q, mode_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          valid_q, valid_d;
   logic          init_q, init_d;
   logic [5:0]    twinkle_q, twinkle_d;

   logic tick, adj;
   logic sec_inc, sec_dec, min_inc, min_dec, hour_inc, hour_dec;
   logic sec_carry, min_carry, day_wrap;

   assign tick = (mode_q == ST_RUN) && (pre_q == PRE_LAST);
   // A mode press swallows any simultaneous value key; inc+dec cancel out.
   assign adj  = !key_mode && (key_inc ^ key_dec);

   // Field steering: ripple carries only in RUN, direct edits only in SET.
   always_comb begin
      sec_inc  = tick || ((mode_q == ST_SET_SEC) && adj && key_inc);
      sec_dec  = (mode_q == ST_SET_SEC) && adj && key_dec;
      min_inc  = ((mode_q == ST_RUN) && sec_carry) ||
                 ((mode_q == ST_SET_MIN) && adj && key_inc);
      min_dec  = (mode_q == ST_SET_MIN) && adj && key_dec;
      hour_inc = ((mode_q == ST_RUN) && min_carry) ||
                 ((mode_q == ST_SET_HOUR) && adj && key_inc);
      hour_dec = (mode_q == ST_SET_HOUR) && adj && key_dec;
   end

   always_comb begin
      mode_d    = mode_q;
      pre_d     = pre_q;
      init_d    = 1'b0;
      twinkle_d = 6'b000_000;
      if (key_mode) begin
         mode_d = next_mode(mode_q);
      end else begin
         mode_d = mode_q;
      end
      if (mode_d != ST_RUN) begin
         pre_d = '0;
      end else if (mode_q != ST_RUN || tick) begin
         pre_d = '0;
      end else begin
         pre_d = pre_q + 1'b1;
      end
      valid_d = init_q || tick || key_mode || day_wrap ||
                ((mode_q != ST_RUN) && adj);
      case (mode_d)
         ST_SET_HOUR: twinkle_d = TW_HOUR;
         ST_SET_MIN:  twinkle_d = TW_MIN;
         ST_SET_SEC:  twinkle_d = TW_SEC;
         default:     twinkle_d = 6'b000_000;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         mode_q    <= ST_RUN;
         pre_q     <= '0;
         valid_q   <= 1'b0;
         init_q    <= 1'b1;
         twinkle_q <= 6'b000_000;
      end else begin
         mode_q    <= mode_d;
         pre_q     <= pre_d;
         valid_q   <= valid_d;
         init_q    <= init_d;
         twinkle_q <= twinkle_d;
      end
   end

   bcd2_cnt #(.MAX(MINSEC_MAX)) u_sec (
      .clk(sysclk), .ld_zero(rst), .inc(sec_inc), .dec(sec_dec),
      .tens(num2), .units(num1), .carry(sec_carry)
   );

   bcd2_cnt #(.MAX(MINSEC_MAX)) u_min (
      .clk(sysclk), .ld_zero(rst), .inc(min_inc), .dec(min_dec),
      .tens(num4), .units(num3), .carry(min_carry)
   );

   bcd2_cnt #(.MAX(HOUR_MAX)) u_hour (
      .clk(sysclk), .ld_zero(rst), .inc(hour_inc), .dec(hour_dec),
      .tens(num6), .units(num5), .carry(day_wrap)
   );

   assign valid_sd = valid_q;
   assign twinkle  = twinkle_q;
   assign mode     = mode_q;
   assign dp       = DP_PATTERN;

endmodule
